// File: rtl/mod_fetch_pc_unit.sv
// Fetch stage: program counter, single-outstanding instruction-memory requester and IF/ID latch.
// state  | meaning
// S_IDLE | first cycle out of reset, no request yet
// S_REQ  | request for pc presented to instruction memory
// S_WAIT | request accepted, waiting for the response
// S_HOLD | response captured in the hold buffer, decode is stalled
module mod_fetch_pc_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] next_address,
  input  logic        branch_taken,
  output logic [31:0] pc_plus_4,
  output logic [31:0] pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        id_stall,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus_4
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

  state_t      state_q;
  logic        drop_q;
  logic [31:0] pc_q;
  logic [31:0] hold_q;
  logic        if_id_valid_q;
  logic [31:0] if_id_instr_q;
  logic [31:0] if_id_pc_q;
  logic [31:0] if_id_pc_plus_4_q;

  logic load_ok;
  logic consume;

  assign pc_plus_4       = pc_q + 32'd4;
  assign pc              = pc_q;
  assign imem_addr       = pc_q;
  assign imem_req_valid  = (state_q == S_REQ);
  assign if_id_valid     = if_id_valid_q;
  assign if_id_instr     = if_id_instr_q;
  assign if_id_pc        = if_id_pc_q;
  assign if_id_pc_plus_4 = if_id_pc_plus_4_q;

  assign load_ok = !if_id_valid_q || !id_stall;
  assign consume = if_id_valid_q && !id_stall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q           <= S_IDLE;
      drop_q            <= 1'b0;
      pc_q              <= RESET_PC;
      hold_q            <= 32'h0;
      if_id_valid_q     <= 1'b0;
      if_id_instr_q     <= NOP_INSTR;
      if_id_pc_q        <= 32'h0;
      if_id_pc_plus_4_q <= 32'h0;
    end else if (branch_taken) begin
      // Redirect wins over everything, including a decode stall.
      pc_q          <= next_address;
      if_id_valid_q <= 1'b0;
      if_id_instr_q <= NOP_INSTR;
      case (state_q)
        S_IDLE: state_q <= S_REQ;
        S_REQ: begin
          if (imem_req_ready) begin
            state_q <= S_WAIT;
            drop_q  <= 1'b1;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            drop_q  <= 1'b0;
            state_q <= S_REQ;
          end else begin
            drop_q  <= 1'b1;
          end
        end
        S_HOLD: state_q <= S_REQ;
        default: state_q <= S_IDLE;
      endcase
    end else begin
      if (consume) begin
        if_id_valid_q <= 1'b0;
      end
      case (state_q)
        S_IDLE: state_q <= S_REQ;
        S_REQ: begin
          if (imem_req_ready) begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            if (drop_q) begin
              drop_q  <= 1'b0;
              state_q <= S_REQ;
            end else if (load_ok) begin
              if_id_valid_q     <= 1'b1;
              if_id_instr_q     <= imem_rsp_data;
              if_id_pc_q        <= pc_q;
              if_id_pc_plus_4_q <= pc_plus_4;
              pc_q              <= next_address;
              state_q           <= S_REQ;
            end else begin
              hold_q  <= imem_rsp_data;
              state_q <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (load_ok) begin
            if_id_valid_q     <= 1'b1;
            if_id_instr_q     <= hold_q;
            if_id_pc_q        <= pc_q;
            if_id_pc_plus_4_q <= pc_plus_4;
            pc_q              <= next_address;
            state_q           <= S_REQ;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
